// File: rtl/uart_rx_timing_pkg.sv
// Shared types and limits for the UART receive timing counter.
// Clamp limits keep the sample midpoint and wrap compares free of underflow.
package uart_rx_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MIN_PRESCALE  = 4;
  localparam int MIN_FRAME_LEN = 1;

endpackage

// File: rtl/uart_rx_edge_div.sv
// Modulo-N clock-position counter; wrap flags the last clock of each bit.
// Latency: count is registered, wrap is decoded from registered state only.
module uart_rx_edge_div #(
  parameter int W = 6
) (
  input  logic         CLK_EDGE,
  input  logic         RST_EDGE,
  input  logic         run,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = (count == (modulus - W'(1)));

  always_ff @(posedge CLK_EDGE or negedge RST_EDGE) begin
    if (!RST_EDGE) begin
      count <= '0;
    end else if (!run || wrap) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_timing_counter.sv
// UART RX bit/frame timing: edge and bit counters, sample strobes, done pulses.
// Outputs decode registered state only; UART_RX_SAMPLE3_EN adds mid-1/mid+1 strobes for majority vote.
module uart_rx_timing_counter
  import uart_rx_timing_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK_EDGE,
  input  logic                  RST_EDGE,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_len,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sample_stb,
  output logic [1:0]            sample_idx,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  busy
);

  localparam logic [PRESCALE_W-1:0] MIN_PRE = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [BIT_CNT_W-1:0]  MIN_LEN = BIT_CNT_W'(MIN_FRAME_LEN);

  state_t                  state_q;
  state_t                  state_d;
  logic [PRESCALE_W-1:0]   pre_q;
  logic [BIT_CNT_W-1:0]    len_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic [PRESCALE_W-1:0]   mid;
  logic                    in_count;
  logic                    edge_run;
  logic                    edge_wrap;
  logic                    last_bit;
  logic                    frame_end;
  logic                    start;

  assign in_count  = (state_q == COUNT);
  assign edge_run  = in_count && enable;
  assign start     = (state_q == IDLE) && enable;
  assign last_bit  = (bit_cnt_q == (len_q - BIT_CNT_W'(1)));
  assign frame_end = in_count && edge_wrap && last_bit;
  assign mid       = pre_q >> 1;

  uart_rx_edge_div #(
    .W (PRESCALE_W)
  ) u_edge_div (
    .CLK_EDGE (CLK_EDGE),
    .RST_EDGE (RST_EDGE),
    .run      (edge_run),
    .modulus  (pre_q),
    .count    (edge_cnt),
    .wrap     (edge_wrap)
  );

  always_ff @(posedge CLK_EDGE or negedge RST_EDGE) begin
    if (!RST_EDGE) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = COUNT;
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (frame_end) begin
          state_d = DONE;
        end
      end
      DONE:    if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame parameters are frozen at start so mid-frame input changes cannot skew bit timing.
  always_ff @(posedge CLK_EDGE or negedge RST_EDGE) begin
    if (!RST_EDGE) begin
      pre_q <= '0;
      len_q <= '0;
    end else if (start) begin
      pre_q <= (prescale < MIN_PRE) ? MIN_PRE : prescale;
      len_q <= (frame_len < MIN_LEN) ? MIN_LEN : frame_len;
    end
  end

  always_ff @(posedge CLK_EDGE or negedge RST_EDGE) begin
    if (!RST_EDGE) begin
      bit_cnt_q <= '0;
    end else if (!edge_run || frame_end) begin
      bit_cnt_q <= '0;
    end else if (edge_wrap) begin
      bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
    end
  end

  assign bit_cnt = bit_cnt_q;

  always_comb begin
    busy       = (state_q != IDLE);
    bit_done   = in_count && edge_wrap;
    frame_done = frame_end;
    sample_stb = 1'b0;
    sample_idx = 2'd0;
`ifdef UART_RX_SAMPLE3_EN
    if (in_count) begin
      if (edge_cnt == (mid - PRESCALE_W'(1))) begin
        sample_stb = 1'b1;
        sample_idx = 2'd0;
      end else if (edge_cnt == mid) begin
        sample_stb = 1'b1;
        sample_idx = 2'd1;
      end else if (edge_cnt == (mid + PRESCALE_W'(1))) begin
        sample_stb = 1'b1;
        sample_idx = 2'd2;
      end
    end
`else
    sample_stb = in_count && (edge_cnt == mid);
`endif
  end

endmodule

// File: tb/tb_uart_rx_timing_counter.sv
// Directed bench for uart_rx_timing_counter; expectations hand-derived from the timing rules.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_timing_counter;

  logic       CLK_EDGE = 1'b0;
  logic       RST_EDGE = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] prescale = '0;
  logic [3:0] frame_len = '0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sample_stb;
  logic [1:0] sample_idx;
  logic       bit_done;
  logic       frame_done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_rx_timing_counter #(
    .PRESCALE_W (6),
    .BIT_CNT_W  (4)
  ) dut (
    .CLK_EDGE   (CLK_EDGE),
    .RST_EDGE   (RST_EDGE),
    .enable     (enable),
    .prescale   (prescale),
    .frame_len  (frame_len),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .sample_stb (sample_stb),
    .sample_idx (sample_idx),
    .bit_done   (bit_done),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 CLK_EDGE = ~CLK_EDGE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_EDGE);
    @(negedge CLK_EDGE);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_edge"}, 32'(edge_cnt), 0);
    check({tag, "_bit"}, 32'(bit_cnt), 0);
    check({tag, "_stb"}, 32'(sample_stb), 0);
    check({tag, "_idx"}, 32'(sample_idx), 0);
    check({tag, "_bdone"}, 32'(bit_done), 0);
    check({tag, "_fdone"}, 32'(frame_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int bd, fd, fd_ok, seq_err, fd_at;
    logic [31:0] stb_mask, idx_pack, bd_mask;

    // Reset held with enable high: block must stay idle with zero outputs.
    prescale = 6'd8;
    frame_len = 4'd10;
    enable = 1'b1;
    step();
    step();
    check_all_zero("reset");
    enable = 1'b0;
    RST_EDGE = 1'b1;
    step();
    check("idle_busy", 32'(busy), 0);

    // Full frame: prescale 8, 10 bits, enable held.
    prescale = 6'd8;
    frame_len = 4'd10;
    enable = 1'b1;
    step();
    check("f1_start_edge", 32'(edge_cnt), 0);
    check("f1_start_bit", 32'(bit_cnt), 0);
    check("f1_start_busy", 32'(busy), 1);
    bd = 0; fd = 0; fd_ok = 0; seq_err = 0;
    for (int i = 0; i < 80; i++) begin
      if (32'(edge_cnt) != 32'(i % 8) || 32'(bit_cnt) != 32'(i / 8)) seq_err++;
      if (bit_done) bd++;
      if (frame_done) begin
        fd++;
        if (bit_done && bd == 10) fd_ok = 1;
      end
      step();
    end
    check("f1_seq_err", 32'(seq_err), 0);
    check("f1_bit_done_cnt", 32'(bd), 10);
    check("f1_frame_done_cnt", 32'(fd), 1);
    check("f1_fd_with_10th_bd", 32'(fd_ok), 1);
    check("f1_done_busy", 32'(busy), 1);
    check("f1_done_edge", 32'(edge_cnt), 0);
    check("f1_done_bit", 32'(bit_cnt), 0);
    step();
    step();
    step();
    check("f1_hold_busy", 32'(busy), 1);
    check("f1_hold_bdone", 32'(bit_done), 0);
    check("f1_hold_fdone", 32'(frame_done), 0);
    enable = 1'b0;
    step();
    check("f1_release_busy", 32'(busy), 0);

    // Sample strobes at prescale 16 (mid = 8).
    prescale = 6'd16;
    frame_len = 4'd1;
    enable = 1'b1;
    step();
    stb_mask = '0;
    idx_pack = '0;
    for (int i = 0; i < 16; i++) begin
      if (sample_stb) begin
        stb_mask[i] = 1'b1;
        idx_pack[2*i +: 2] = sample_idx;
      end
      step();
    end
`ifdef UART_RX_SAMPLE3_EN
    check("smp_mask", stb_mask, 32'h0000_0380);
    check("smp_idx", idx_pack, 32'h0009_0000);
`else
    check("smp_mask", stb_mask, 32'h0000_0100);
    check("smp_idx", idx_pack, 32'h0000_0000);
`endif
    check("smp_done_busy", 32'(busy), 1);
    check("smp_done_stb", 32'(sample_stb), 0);
    enable = 1'b0;
    step();

    // Clamp: prescale 2 / frame_len 0 behaves as 4 / 1.
    prescale = 6'd2;
    frame_len = 4'd0;
    enable = 1'b1;
    step();
    fd = 0;
    fd_at = -1;
    for (int i = 0; i < 8; i++) begin
      if (frame_done) begin
        fd++;
        fd_at = i;
      end
      step();
    end
    check("clamp_fd_cnt", 32'(fd), 1);
    check("clamp_fd_at", 32'(fd_at), 3);
    enable = 1'b0;
    step();

    // Abort at bit 3, edge 5.
    prescale = 6'd8;
    frame_len = 4'd10;
    enable = 1'b1;
    step();
    repeat (29) step();
    check("abort_pre_edge", 32'(edge_cnt), 5);
    check("abort_pre_bit", 32'(bit_cnt), 3);
    enable = 1'b0;
    step();
    check("abort_busy", 32'(busy), 0);
    check("abort_edge", 32'(edge_cnt), 0);
    check("abort_bit", 32'(bit_cnt), 0);
    fd = 0;
    for (int i = 0; i < 10; i++) begin
      if (frame_done) fd++;
      step();
    end
    check("abort_no_fd", 32'(fd), 0);

    // Inputs changed mid-frame must not alter the latched timing.
    prescale = 6'd8;
    frame_len = 4'd4;
    enable = 1'b1;
    step();
    bd_mask = '0;
    fd_at = -1;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) begin
        check("chg_bit_at16", 32'(bit_cnt), 2);
        prescale = 6'd16;
        frame_len = 4'd1;
      end
      if (bit_done) bd_mask[i] = 1'b1;
      if (frame_done) fd_at = i;
      step();
    end
    check("chg_bd_mask", bd_mask, 32'h8080_8080);
    check("chg_fd_at", 32'(fd_at), 31);
    check("chg_done_busy", 32'(busy), 1);
    enable = 1'b0;
    step();

    // Asynchronous reset mid-frame, then a clean restart.
    prescale = 6'd8;
    frame_len = 4'd10;
    enable = 1'b1;
    step();
    repeat (12) step();
    check("rst_pre_edge", 32'(edge_cnt), 4);
    check("rst_pre_bit", 32'(bit_cnt), 1);
    check("rst_pre_stb", 32'(sample_stb), 1);
    #2;
    RST_EDGE = 1'b0;
    #1;
    check_all_zero("rst_async");
    enable = 1'b0;
    @(negedge CLK_EDGE);
    RST_EDGE = 1'b1;
    step();
    check("rst_idle_busy", 32'(busy), 0);
    enable = 1'b1;
    step();
    check("rst_new_edge", 32'(edge_cnt), 0);
    check("rst_new_bit", 32'(bit_cnt), 0);
    check("rst_new_busy", 32'(busy), 1);
    repeat (7) step();
    check("rst_new_bdone", 32'(bit_done), 1);
    check("rst_new_fdone", 32'(frame_done), 0);
    step();
    check("rst_new_bit1", 32'(bit_cnt), 1);
    check("rst_new_edge0", 32'(edge_cnt), 0);
    enable = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
